// File: rtl/tpu_package.sv
// Shared opcode and sequencer state types for the
// matmul tile sequencer and its helpers.
package tpu_package;

    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_MATMUL_OVR = 3'd1,
        OP_MATMUL_ACC = 3'd2
    } mac_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT_W = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_e;

    // Only the two matmul flavours do real work; all else is a NOP.
    function automatic logic is_matmul(input logic [2:0] op);
        return (op == OP_MATMUL_OVR) || (op == OP_MATMUL_ACC);
    endfunction

endpackage

// File: rtl/acc_write_delay_line.sv
// Fixed-latency shift line carrying accumulator write requests
// alongside the rows travelling through the systolic array.
module acc_write_delay_line #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              in_valid_i,
    input  logic              in_add_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    output logic              out_valid_o,
    output logic              out_add_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              pending_o
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_add;
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic w_pending;

    // Advance every stage together when not frozen; reset drops all entries.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_add   <= '0;
            for (int i = 0; i < DEPTH; i++) r_addr[i] <= '0;
        end else if (en_i) begin
            r_valid[0] <= in_valid_i;
            r_add[0]   <= in_add_i;
            r_addr[0]  <= in_addr_i;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_add[i]   <= r_add[i-1];
                r_addr[i]  <= r_addr[i-1];
            end
        end
    end

    // Any entry still upstream of the output stage.
    always_comb begin
        w_pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) w_pending = w_pending | r_valid[i];
    end

    assign out_valid_o = r_valid[DEPTH-1];
    assign out_add_o   = r_add[DEPTH-1];
    assign out_addr_o  = r_addr[DEPTH-1];
    assign pending_o   = w_pending;

endmodule

// File: rtl/matmul_tile_sequencer.sv
// Walks u/k/r loops of a tiled matmul, issuing activation rows
// and scheduling delayed accumulator writes for each row.
module matmul_tile_sequencer
    import tpu_package::*;
#(
    parameter int MUL_SIZE   = 16,
    parameter int DIM_W      = 8,
    parameter int UB_ADDR_W  = 12,
    parameter int ACC_ADDR_W = 10,
    parameter int PIPE_LAT   = 2 * MUL_SIZE
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  logic [2:0]            MAC_op_i,
    input  logic [DIM_W-1:0]      V_dim_i,
    input  logic [DIM_W-1:0]      U_tiles_i,
    input  logic [DIM_W-1:0]      ITER_tiles_i,
    input  logic [UB_ADDR_W-1:0]  ub_start_addr_i,
    input  logic                  weights_rdy_i,
    input  logic                  stall_i,
    output logic                  next_weight_tile_o,
    output logic                  ub_read_en_o,
    output logic [UB_ADDR_W-1:0]  ub_addr_rd_o,
    output logic                  MAC_compute_o,
    output logic                  acc_write_o,
    output logic                  acc_add_o,
    output logic [ACC_ADDR_W-1:0] acc_addr_wr_o,
    output logic                  busy_o,
    output logic                  done_o
);

    seq_state_e            r_state;
    logic [2:0]            r_op;
    logic [DIM_W-1:0]      r_v;
    logic [DIM_W-1:0]      r_u_tiles;
    logic [DIM_W-1:0]      r_k_tiles;
    logic [DIM_W-1:0]      r_r;
    logic [DIM_W-1:0]      r_k;
    logic [DIM_W-1:0]      r_u;
    logic [UB_ADDR_W-1:0]  r_start;
    logic [UB_ADDR_W-1:0]  r_rd_addr;
    logic [ACC_ADDR_W-1:0] r_wr_base;

    logic                  w_run;
    logic                  w_nop;
    logic                  w_issue;
    logic                  w_last_r;
    logic                  w_last_k;
    logic                  w_last_u;
    logic                  w_add;
    logic [ACC_ADDR_W-1:0] w_wr_addr;
    logic                  w_dl_valid;
    logic                  w_dl_add;
    logic [ACC_ADDR_W-1:0] w_dl_addr;
    logic                  w_dl_pending;

    assign w_run = !stall_i;

    assign w_nop = !is_matmul(MAC_op_i)
                || (V_dim_i == '0)
                || (U_tiles_i == '0)
                || (ITER_tiles_i == '0);

    assign w_issue  = (r_state == ST_STREAM) && w_run;
    assign w_last_r = (r_r == r_v - DIM_W'(1));
    assign w_last_k = (r_k == r_k_tiles - DIM_W'(1));
    assign w_last_u = (r_u == r_u_tiles - DIM_W'(1));

    // First reduction step of an overwrite matmul seeds the accumulator.
    assign w_add = (r_op == OP_MATMUL_ACC) || (r_k != '0);

    // Rows of output tile u land in the accumulator at u*V + r.
    assign w_wr_addr = r_wr_base + ACC_ADDR_W'(r_r);

    // Main sequencer: instruction accept, loop counters and state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_op      <= '0;
            r_v       <= '0;
            r_u_tiles <= '0;
            r_k_tiles <= '0;
            r_r       <= '0;
            r_k       <= '0;
            r_u       <= '0;
            r_start   <= '0;
            r_rd_addr <= '0;
            r_wr_base <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid_i) begin
                        r_op      <= MAC_op_i;
                        r_v       <= V_dim_i;
                        r_u_tiles <= U_tiles_i;
                        r_k_tiles <= ITER_tiles_i;
                        r_start   <= ub_start_addr_i;
                        r_rd_addr <= ub_start_addr_i;
                        r_r       <= '0;
                        r_k       <= '0;
                        r_u       <= '0;
                        r_wr_base <= '0;
                        r_state   <= w_nop ? ST_DONE : ST_WAIT_W;
                    end
                end
                ST_WAIT_W: begin
                    if (w_run && weights_rdy_i) r_state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (w_run) begin
                        if (w_last_r) begin
                            r_r <= '0;
                            if (w_last_k) begin
                                r_k       <= '0;
                                r_rd_addr <= r_start;
                                if (w_last_u) begin
                                    r_state <= ST_DRAIN;
                                end else begin
                                    r_u       <= r_u + DIM_W'(1);
                                    r_wr_base <= r_wr_base + ACC_ADDR_W'(r_v);
                                    r_state   <= ST_WAIT_W;
                                end
                            end else begin
                                r_k       <= r_k + DIM_W'(1);
                                r_rd_addr <= r_rd_addr + UB_ADDR_W'(1);
                                r_state   <= ST_WAIT_W;
                            end
                        end else begin
                            r_r       <= r_r + DIM_W'(1);
                            r_rd_addr <= r_rd_addr + UB_ADDR_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // Leave once only the output stage can still hold a write.
                    if (w_run && !w_dl_pending) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    acc_write_delay_line #(
        .DEPTH  (PIPE_LAT),
        .ADDR_W (ACC_ADDR_W)
    ) u_wr_dly (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (w_run),
        .in_valid_i  (w_issue),
        .in_add_i    (w_add),
        .in_addr_i   (w_wr_addr),
        .out_valid_o (w_dl_valid),
        .out_add_o   (w_dl_add),
        .out_addr_o  (w_dl_addr),
        .pending_o   (w_dl_pending)
    );

    assign instr_ready_o      = (r_state == ST_IDLE);
    assign busy_o             = (r_state != ST_IDLE);
    assign done_o             = (r_state == ST_DONE);
    assign ub_read_en_o       = w_issue;
    assign MAC_compute_o      = w_issue;
    assign ub_addr_rd_o       = w_issue ? r_rd_addr : '0;
    assign next_weight_tile_o = w_issue && w_last_r;
    assign acc_write_o        = w_dl_valid && w_run;
    assign acc_add_o          = acc_write_o && w_dl_add;
    assign acc_addr_wr_o      = acc_write_o ? w_dl_addr : '0;

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Testbench for matmul_tile_sequencer: directed scenarios plus
// randomized runs checked against a loop-level reference model.
module tb_matmul_tile_sequencer;

    localparam int PL  = 4;
    localparam int UAW = 12;
    localparam int AAW = 10;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [2:0]  MAC_op_i;
    logic [7:0]  V_dim_i;
    logic [7:0]  U_tiles_i;
    logic [7:0]  ITER_tiles_i;
    logic [11:0] ub_start_addr_i;
    logic        weights_rdy_i;
    logic        stall_i;
    logic        next_weight_tile_o;
    logic        ub_read_en_o;
    logic [11:0] ub_addr_rd_o;
    logic        MAC_compute_o;
    logic        acc_write_o;
    logic        acc_add_o;
    logic [9:0]  acc_addr_wr_o;
    logic        busy_o;
    logic        done_o;

    matmul_tile_sequencer #(
        .MUL_SIZE   (4),
        .DIM_W      (8),
        .UB_ADDR_W  (UAW),
        .ACC_ADDR_W (AAW),
        .PIPE_LAT   (PL)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .instr_valid_i      (instr_valid_i),
        .instr_ready_o      (instr_ready_o),
        .MAC_op_i           (MAC_op_i),
        .V_dim_i            (V_dim_i),
        .U_tiles_i          (U_tiles_i),
        .ITER_tiles_i       (ITER_tiles_i),
        .ub_start_addr_i    (ub_start_addr_i),
        .weights_rdy_i      (weights_rdy_i),
        .stall_i            (stall_i),
        .next_weight_tile_o (next_weight_tile_o),
        .ub_read_en_o       (ub_read_en_o),
        .ub_addr_rd_o       (ub_addr_rd_o),
        .MAC_compute_o      (MAC_compute_o),
        .acc_write_o        (acc_write_o),
        .acc_add_o          (acc_add_o),
        .acc_addr_wr_o      (acc_addr_wr_o),
        .busy_o             (busy_o),
        .done_o             (done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ucyc     = 0;
    int g_acc;
    bit rnd_en   = 1'b0;

    int rd_addr_q[$];
    int rd_t_q[$];
    int rd_u_q[$];
    int wr_addr_q[$];
    int wr_add_q[$];
    int wr_t_q[$];
    int wr_u_q[$];
    int pulse_cnt;
    int done_cnt;
    int done_t;
    int gate_viol;

    int exp_rd[$];
    int exp_wa[$];
    int exp_wadd[$];
    int exp_pulses;

    int base_done_off;
    int base_first_rd_off;
    int base_last_wr_off;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (ub_read_en_o) begin
            rd_addr_q.push_back(int'(ub_addr_rd_o));
            rd_t_q.push_back(cyc);
            rd_u_q.push_back(ucyc);
        end
        if (acc_write_o) begin
            wr_addr_q.push_back(int'(acc_addr_wr_o));
            wr_add_q.push_back(int'(acc_add_o));
            wr_t_q.push_back(cyc);
            wr_u_q.push_back(ucyc);
        end
        if (next_weight_tile_o) pulse_cnt++;
        if (done_o) begin
            done_cnt++;
            done_t = cyc;
        end
        if (stall_i && (ub_read_en_o || MAC_compute_o
                        || acc_write_o || next_weight_tile_o))
            gate_viol++;
        if (MAC_compute_o !== ub_read_en_o) gate_viol++;
        if (!stall_i) ucyc++;
    end

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (rnd_en) begin
                stall_i       = ($urandom_range(0, 3) == 0);
                weights_rdy_i = ($urandom_range(0, 2) != 0);
            end
        end
    end

    // Expected traffic straight from the u/k/r loop nest.
    function automatic void build_model(int op, int v, int u, int it, int st);
        exp_rd.delete();
        exp_wa.delete();
        exp_wadd.delete();
        exp_pulses = 0;
        if (!((op == 1 || op == 2) && v > 0 && u > 0 && it > 0)) return;
        for (int uu = 0; uu < u; uu++)
            for (int kk = 0; kk < it; kk++)
                for (int rr = 0; rr < v; rr++) begin
                    exp_rd.push_back((st + kk * v + rr) % (1 << UAW));
                    exp_wa.push_back((uu * v + rr) % (1 << AAW));
                    exp_wadd.push_back((op == 2) ? 1 : int'(kk != 0));
                end
        exp_pulses = u * it;
    endfunction

    task automatic clear_mon();
        rd_addr_q.delete();
        rd_t_q.delete();
        rd_u_q.delete();
        wr_addr_q.delete();
        wr_add_q.delete();
        wr_t_q.delete();
        wr_u_q.delete();
        pulse_cnt = 0;
        done_cnt  = 0;
        done_t    = -1;
        gate_viol = 0;
    endtask

    task automatic send(input int op, input int v, input int u,
                        input int it, input int st);
        bit rdy;
        @(posedge clk_i);
        #1;
        clear_mon();
        instr_valid_i   = 1'b1;
        MAC_op_i        = 3'(op);
        V_dim_i         = 8'(v);
        U_tiles_i       = 8'(u);
        ITER_tiles_i    = 8'(it);
        ub_start_addr_i = 12'(st);
        g_acc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            rdy = instr_ready_o;
            @(posedge clk_i);
            #1;
            if (rdy) begin
                g_acc = cyc;
                break;
            end
        end
        instr_valid_i = 1'b0;
        n_checks++;
        if (g_acc < 0) begin
            n_fail++;
            $display("FAIL accept: instr_ready_o never seen, got 0 required 1");
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_i);
            #1;
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        n_checks++;
        if (instr_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %0b required 1", instr_ready_o);
        end
        n_checks++;
        if ({busy_o, done_o, ub_read_en_o, MAC_compute_o, acc_write_o,
             acc_add_o, next_weight_tile_o} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b required 0",
                     {busy_o, done_o, ub_read_en_o, MAC_compute_o,
                      acc_write_o, acc_add_o, next_weight_tile_o});
        end
        n_checks++;
        if ({ub_addr_rd_o, acc_addr_wr_o} !== 22'b0) begin
            n_fail++;
            $display("FAIL reset_addr: got %0h/%0h required 0",
                     ub_addr_rd_o, acc_addr_wr_o);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic test_nop();
        bit ok;
        int ops[4] = '{0, 5, 1, 2};
        int vs[4]  = '{3, 3, 0, 2};
        int us[4]  = '{2, 2, 2, 0};
        for (int c = 0; c < 4; c++) begin
            send(ops[c], vs[c], us[c], 2, 'h20);
            wait_done(10, ok);
            n_checks++;
            if (done_cnt !== 1 || done_t !== g_acc) begin
                n_fail++;
                $display("FAIL nop_done[%0d]: got cnt %0d at %0d required 1 at %0d",
                         c, done_cnt, done_t, g_acc);
            end
            n_checks++;
            if (rd_addr_q.size() + wr_addr_q.size() + pulse_cnt !== 0) begin
                n_fail++;
                $display("FAIL nop_quiet[%0d]: got %0d events required 0",
                         c, rd_addr_q.size() + wr_addr_q.size() + pulse_cnt);
            end
        end
    endtask

    task automatic test_matmul(input string tag, input int op, input int v,
                               input int u, input int it, input int st);
        bit ok;
        int n;
        build_model(op, v, u, it, st);
        send(op, v, u, it, st);
        wait_done(3000, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s timeout: got no done_o required 1", tag);
            rst_i = 1'b1;
            @(posedge clk_i);
            #1;
            rst_i = 1'b0;
        end
        n_checks++;
        if (rd_addr_q.size() !== exp_rd.size()) begin
            n_fail++;
            $display("FAIL %s rd_count: got %0d required %0d",
                     tag, rd_addr_q.size(), exp_rd.size());
        end
        n = (rd_addr_q.size() < exp_rd.size()) ? rd_addr_q.size() : exp_rd.size();
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (rd_addr_q[i] !== exp_rd[i]) begin
                n_fail++;
                $display("FAIL %s rd_addr[%0d]: got %0h required %0h",
                         tag, i, rd_addr_q[i], exp_rd[i]);
            end
        end
        n_checks++;
        if (wr_addr_q.size() !== exp_wa.size()) begin
            n_fail++;
            $display("FAIL %s wr_count: got %0d required %0d",
                     tag, wr_addr_q.size(), exp_wa.size());
        end
        n = (wr_addr_q.size() < exp_wa.size()) ? wr_addr_q.size() : exp_wa.size();
        if (rd_u_q.size() < n) n = rd_u_q.size();
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (wr_addr_q[i] !== exp_wa[i] || wr_add_q[i] !== exp_wadd[i]) begin
                n_fail++;
                $display("FAIL %s wr[%0d]: got addr %0h add %0d required addr %0h add %0d",
                         tag, i, wr_addr_q[i], wr_add_q[i], exp_wa[i], exp_wadd[i]);
            end
            n_checks++;
            if (wr_u_q[i] - rd_u_q[i] !== PL) begin
                n_fail++;
                $display("FAIL %s wr_latency[%0d]: got %0d required %0d",
                         tag, i, wr_u_q[i] - rd_u_q[i], PL);
            end
        end
        n_checks++;
        if (pulse_cnt !== exp_pulses) begin
            n_fail++;
            $display("FAIL %s pulses: got %0d required %0d", tag, pulse_cnt, exp_pulses);
        end
        n_checks++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL %s done_count: got %0d required 1", tag, done_cnt);
        end
        if (wr_t_q.size() > 0) begin
            n_checks++;
            if (done_t !== wr_t_q[wr_t_q.size()-1] + 1) begin
                n_fail++;
                $display("FAIL %s done_after_drain: got %0d required %0d",
                         tag, done_t, wr_t_q[wr_t_q.size()-1] + 1);
            end
        end
        n_checks++;
        if (gate_viol !== 0) begin
            n_fail++;
            $display("FAIL %s stall_gating: got %0d violations required 0", tag, gate_viol);
        end
    endtask

    task automatic test_basic();
        test_matmul("ovr_basic", 1, 3, 2, 2, 'h10);
        base_done_off     = done_t - g_acc;
        base_first_rd_off = (rd_t_q.size() > 0) ? rd_t_q[0] - g_acc : -1;
        base_last_wr_off  = (wr_t_q.size() > 0) ? wr_t_q[wr_t_q.size()-1] - g_acc : -1;
    endtask

    task automatic test_stall();
        bit ok;
        int errs;
        build_model(1, 3, 2, 2, 'h10);
        send(1, 3, 2, 2, 'h10);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk_i);
            #1;
            if (rd_addr_q.size() >= 2) break;
        end
        stall_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        stall_i = 1'b0;
        wait_done(200, ok);
        errs = 0;
        if (rd_addr_q.size() != exp_rd.size() || wr_addr_q.size() != exp_wa.size())
            errs++;
        else begin
            foreach (exp_rd[i]) if (rd_addr_q[i] != exp_rd[i]) errs++;
            foreach (exp_wa[i])
                if (wr_addr_q[i] != exp_wa[i] || wr_add_q[i] != exp_wadd[i]
                    || wr_u_q[i] - rd_u_q[i] != PL) errs++;
        end
        n_checks++;
        if (errs !== 0) begin
            n_fail++;
            $display("FAIL stall_sequence: got %0d bad entries required 0", errs);
        end
        n_checks++;
        if (rd_t_q.size() == 0 || rd_t_q[0] - g_acc !== base_first_rd_off) begin
            n_fail++;
            $display("FAIL stall_first_rd: got offset %0d required %0d",
                     (rd_t_q.size() > 0) ? rd_t_q[0] - g_acc : -1, base_first_rd_off);
        end
        n_checks++;
        if (wr_t_q.size() == 0
            || wr_t_q[wr_t_q.size()-1] - g_acc !== base_last_wr_off + 3) begin
            n_fail++;
            $display("FAIL stall_last_wr: got offset %0d required %0d",
                     (wr_t_q.size() > 0) ? wr_t_q[wr_t_q.size()-1] - g_acc : -1,
                     base_last_wr_off + 3);
        end
        n_checks++;
        if (done_cnt !== 1 || done_t - g_acc !== base_done_off + 3) begin
            n_fail++;
            $display("FAIL stall_done: got cnt %0d offset %0d required 1 offset %0d",
                     done_cnt, done_t - g_acc, base_done_off + 3);
        end
        n_checks++;
        if (pulse_cnt !== 4 || gate_viol !== 0) begin
            n_fail++;
            $display("FAIL stall_pulses: got %0d pulses %0d gating errors required 4 and 0",
                     pulse_cnt, gate_viol);
        end
    endtask

    task automatic test_wait_weights();
        bit ok;
        int rise;
        weights_rdy_i = 1'b0;
        send(2, 2, 1, 1, 'h40);
        repeat (5) @(posedge clk_i);
        #1;
        weights_rdy_i = 1'b1;
        rise = cyc;
        wait_done(100, ok);
        n_checks++;
        if (rd_t_q.size() !== 2 || rd_t_q[0] !== rise + 1) begin
            n_fail++;
            $display("FAIL wait_w_start: got %0d reads first at %0d required 2 at %0d",
                     rd_t_q.size(), (rd_t_q.size() > 0) ? rd_t_q[0] : -1, rise + 1);
        end
        n_checks++;
        if (wr_add_q.size() !== 2 || wr_add_q[0] !== 1 || wr_add_q[1] !== 1) begin
            n_fail++;
            $display("FAIL wait_w_acc_add: got %0d writes adds %p required 2 writes add 1",
                     wr_add_q.size(), wr_add_q);
        end
        n_checks++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL wait_w_done: got %0d required 1", done_cnt);
        end
    endtask

    task automatic test_reset_drain();
        int last;
        last = -1;
        send(1, 3, 1, 1, 'h80);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (next_weight_tile_o) begin
                last = cyc;
                break;
            end
        end
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (instr_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_drain_ready: got ready %0b busy %0b required 1 0",
                     instr_ready_o, busy_o);
        end
        repeat (10) @(posedge clk_i);
        #1;
        n_checks++;
        if (last < 0 || wr_t_q.size() !== 1
            || (wr_t_q.size() > 0 && wr_t_q[wr_t_q.size()-1] >= last + 3)) begin
            n_fail++;
            $display("FAIL rst_drain_writes: got %0d writes required 1 before reset",
                     wr_t_q.size());
        end
        n_checks++;
        if (done_cnt !== 0) begin
            n_fail++;
            $display("FAIL rst_drain_done: got %0d required 0", done_cnt);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            rnd_en = 1'b1;
            test_matmul($sformatf("rand%0d", n), $urandom_range(1, 2),
                        $urandom_range(1, 4), $urandom_range(1, 3),
                        $urandom_range(1, 3), $urandom_range(0, 4095));
            rnd_en = 1'b0;
            stall_i = 1'b0;
            weights_rdy_i = 1'b1;
        end
    endtask

    initial begin
        rst_i           = 1'b1;
        instr_valid_i   = 1'b0;
        MAC_op_i        = '0;
        V_dim_i         = '0;
        U_tiles_i       = '0;
        ITER_tiles_i    = '0;
        ub_start_addr_i = '0;
        weights_rdy_i   = 1'b1;
        stall_i         = 1'b0;
        clear_mon();
        test_reset();
        test_nop();
        test_basic();
        test_stall();
        test_wait_weights();
        test_matmul("addr_wrap", 1, 4, 1, 1, 'hFFE);
        test_reset_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
